// File: rtl/my_sample_serializer.sv
// Four-channel frame capture with saturating offset subtraction, serialised as a
// channel-tagged valid/ready stream through an active + pending frame buffer.
module my_sample_serializer #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           frame_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] frame_data,
  input  logic [CHANNELS*DATA_WIDTH-1:0] offset_data,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [1:0]                     out_channel,
  input  logic                           clear_overrun,
  output logic                           overrun,
  output logic [7:0]                     overrun_count
);

  typedef enum logic {StIdle, StSend} state_e;

  // 17-bit difference, clamped back into the signed 16-bit range.
  function automatic logic [DATA_WIDTH-1:0] sat_sub(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] d;
    d = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    if (d[DATA_WIDTH] != d[DATA_WIDTH-1]) begin
      return d[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return d[DATA_WIDTH-1:0];
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] active_q [CHANNELS];
  logic [DATA_WIDTH-1:0] active_d [CHANNELS];
  logic [DATA_WIDTH-1:0] pending_q [CHANNELS];
  logic [DATA_WIDTH-1:0] pending_d [CHANNELS];
  logic [DATA_WIDTH-1:0] new_frame [CHANNELS];
  logic                  pending_full_q, pending_full_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]            out_channel_q, out_channel_d;
  logic                  beat, last_beat, drop;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      new_frame[c] = sat_sub(frame_data[c*DATA_WIDTH +: DATA_WIDTH],
                             offset_data[c*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign beat      = (state_q == StSend) && out_ready;
  assign last_beat = beat && (idx_q == 2'(CHANNELS - 1));

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    drop           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_valid) begin
          active_d = new_frame;
          idx_d    = 2'd0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (last_beat) begin
          idx_d = 2'd0;
          if (pending_full_q) begin
            // Promote pending; a frame arriving now refills it, so no overrun.
            active_d = pending_q;
            if (frame_valid) begin
              pending_d = new_frame;
            end else begin
              pending_full_d = 1'b0;
            end
          end else if (frame_valid) begin
            active_d = new_frame;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (beat) begin
            idx_d = idx_q + 2'd1;
          end
          if (frame_valid) begin
            if (!pending_full_q) begin
              pending_d      = new_frame;
              pending_full_d = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    count_d   = count_q;
    if (drop) begin
      overrun_d = 1'b1;
      if (clear_overrun) begin
        count_d = 8'd1;
      end else if (count_q != 8'hff) begin
        count_d = count_q + 8'd1;
      end
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
      count_d   = 8'd0;
    end
  end

  always_comb begin
    out_valid_d   = (state_d == StSend);
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    if (out_valid_d) begin
      out_data_d    = active_d[idx_d];
      out_channel_d = idx_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      idx_q          <= 2'd0;
      pending_full_q <= 1'b0;
      overrun_q      <= 1'b0;
      count_q        <= 8'd0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_channel_q  <= 2'd0;
      for (int c = 0; c < CHANNELS; c++) begin
        active_q[c]  <= '0;
        pending_q[c] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pending_full_q <= pending_full_d;
      overrun_q      <= overrun_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_channel_q  <= out_channel_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_channel   = out_channel_q;
  assign overrun       = overrun_q;
  assign overrun_count = count_q;

endmodule

// File: tb/tb_my_sample_serializer.sv
// Randomised and directed bench for my_sample_serializer against a queue-based model of
// the expected beat stream and overrun counter.
module tb_my_sample_serializer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic [63:0] frame_data = '0;
  logic [63:0] offset_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_channel;
  logic        clear_overrun = 1'b0;
  logic        overrun;
  logic [7:0]  overrun_count;

  int checks = 0;
  int errors = 0;

  // Model: every beat still owed downstream, in order, plus the overrun state.
  logic [1:0]  exp_ch[$];
  logic [15:0] exp_data[$];
  logic        m_ovr = 1'b0;
  int          m_cnt = 0;

  my_sample_serializer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .offset_data  (offset_data),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_channel  (out_channel),
    .clear_overrun(clear_overrun),
    .overrun      (overrun),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int s, input int o);
    int d;
    d = s - o;
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return d;
  endfunction

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic tick();
    int held;
    logic signed [15:0] s, o;
    bit dropped;
    @(posedge clk);
    if (exp_data.size() > 0 && out_ready) begin
      void'(exp_ch.pop_front());
      void'(exp_data.pop_front());
    end
    dropped = 1'b0;
    if (frame_valid) begin
      held = (exp_data.size() + 3) / 4;
      if (held < 2) begin
        for (int c = 0; c < 4; c++) begin
          s = frame_data[c*16 +: 16];
          o = offset_data[c*16 +: 16];
          exp_ch.push_back(2'(c));
          exp_data.push_back(16'(sat(int'(s), int'(o))));
        end
      end else begin
        dropped = 1'b1;
      end
    end
    if (dropped) begin
      m_ovr = 1'b1;
      m_cnt = clear_overrun ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    end else if (clear_overrun) begin
      m_ovr = 1'b0;
      m_cnt = 0;
    end
    #1;
  endtask

  task automatic rnd_frame();
    frame_valid = 1'b1;
    frame_data  = {$urandom, $urandom};
    offset_data = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", out_data); end
    checks++; if (out_channel !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", out_channel); end
    checks++; if (overrun !== 1'b0 || overrun_count !== 8'd0) begin
      errors++; $display("FAIL reset_ovr: got %b/%0d want 0/0", overrun, overrun_count);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [15:0] want;
    out_ready   = 1'b1;
    frame_valid = 1'b1;
    frame_data  = {16'd400, 16'd300, 16'd200, 16'd100};
    offset_data = '0;
    tick();
    frame_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      want = 16'(100 * (k + 1));
      if (k < 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_channel !== 2'(k) || out_data !== want) begin
          errors++;
          $display("FAIL single_beat%0d: got v%b ch%0d %0d want v1 ch%0d %0d",
                   k, out_valid, out_channel, out_data, k, want);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    logic [15:0] want[3];
    want[0] = 16'h7fff; want[1] = 16'h8000; want[2] = 16'hfe0c;
    out_ready   = 1'b1;
    frame_valid = 1'b1;
    frame_data  = {16'd5, 16'd1000, 16'h8000, 16'h7fff};
    offset_data = {16'd2, 16'd1500, 16'd1, 16'hffff};
    tick();
    frame_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== want[k]) begin
          errors++; $display("FAIL sat_ch%0d: got v%b %0h want v1 %0h", k, out_valid, out_data, want[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    rnd_frame();
    out_ready = 1'b1;
    tick();
    frame_valid = 1'b0;
    for (int i = 0; i < 18; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      checks++;
      if (out_valid !== (exp_data.size() > 0)) begin
        errors++; $display("FAIL bp_valid: got %b want %b", out_valid, exp_data.size() > 0);
      end
      if (exp_data.size() > 0) begin
        checks++;
        if (out_channel !== exp_ch[0] || out_data !== exp_data[0]) begin
          errors++; $display("FAIL bp_beat: got ch%0d %0h want ch%0d %0h",
                             out_channel, out_data, exp_ch[0], exp_data[0]);
        end
      end
      if (out_valid && out_ready) beats++;
      tick();
    end
    checks++; if (beats != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", beats); end
  endtask

  task automatic test_double_buffer();
    int run = 0;
    out_ready = 1'b0;
    rnd_frame(); tick();
    rnd_frame(); tick();
    frame_valid = 1'b0;
    repeat (4) tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== (exp_data.size() > 0)) begin
        errors++; $display("FAIL db_valid: got %b want %b", out_valid, exp_data.size() > 0);
      end
      if (exp_data.size() > 0) begin
        checks++;
        if (out_channel !== exp_ch[0] || out_data !== exp_data[0]) begin
          errors++; $display("FAIL db_beat: got ch%0d %0h want ch%0d %0h",
                             out_channel, out_data, exp_ch[0], exp_data[0]);
        end
      end
      if (i < 8 && out_valid) run++;
      tick();
    end
    checks++; if (run != 8) begin errors++; $display("FAIL db_nogap: got %0d want 8", run); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL db_no_ovr: got %b want 0", overrun); end
    // Third frame while A stalls mid-frame with B pending.
    rnd_frame(); tick();
    frame_valid = 1'b0; tick();
    out_ready = 1'b0;
    rnd_frame(); tick();
    rnd_frame(); tick();
    frame_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || overrun_count !== 8'd1) begin
      errors++; $display("FAIL db_drop: got %b/%0d want 1/1", overrun, overrun_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (exp_data.size() > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_channel !== exp_ch[0] || out_data !== exp_data[0]) begin
          errors++; $display("FAIL db_drain: got v%b ch%0d %0h want v1 ch%0d %0h",
                             out_valid, out_channel, out_data, exp_ch[0], exp_data[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_overrun_sat();
    out_ready = 1'b0;
    rnd_frame(); tick();
    rnd_frame(); tick();
    repeat (300) begin rnd_frame(); tick(); end
    frame_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || overrun_count !== 8'd255) begin
      errors++; $display("FAIL ovr_sat: got %b/%0d want 1/255", overrun, overrun_count);
    end
    clear_overrun = 1'b1; tick();
    checks++;
    if (overrun !== 1'b0 || overrun_count !== 8'd0) begin
      errors++; $display("FAIL ovr_clear: got %b/%0d want 0/0", overrun, overrun_count);
    end
    rnd_frame(); tick();
    clear_overrun = 1'b0; frame_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || overrun_count !== 8'd1) begin
      errors++; $display("FAIL ovr_clear_drop: got %b/%0d want 1/1", overrun, overrun_count);
    end
    checks++;
    if (overrun !== m_ovr || int'(overrun_count) != m_cnt) begin
      errors++; $display("FAIL ovr_model: got %b/%0d want %b/%0d", overrun, overrun_count, m_ovr, m_cnt);
    end
    out_ready = 1'b1;
    repeat (9) tick();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    rnd_frame(); tick();
    rnd_frame(); tick();
    frame_valid = 1'b0; tick();
    #2 reset_n = 1'b0;
    exp_ch.delete(); exp_data.delete(); m_ovr = 1'b0; m_cnt = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || out_channel !== 2'd0) begin
      errors++; $display("FAIL rst_mid: got v%b ch%0d %0h want v0 ch0 0", out_valid, out_channel, out_data);
    end
    @(negedge clk); reset_n = 1'b1;
    frame_valid = 1'b1;
    frame_data  = {16'd44, 16'd33, 16'd22, 16'd11};
    offset_data = {16'd4, 16'd3, 16'd2, 16'd1};
    tick();
    frame_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k < 4) begin
        if (out_valid !== 1'b1 || out_channel !== 2'(k) || out_data !== 16'(10 * (k + 1))) begin
          errors++; $display("FAIL rst_restart%0d: got v%b ch%0d %0d want v1 ch%0d %0d",
                             k, out_valid, out_channel, out_data, k, 10 * (k + 1));
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_stale: got v%b want v0", out_valid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      out_ready     = ($urandom_range(0, 9) < 7);
      clear_overrun = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) rnd_frame();
      else frame_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== (exp_data.size() > 0)) begin
        errors++; $display("FAIL rnd_valid: cycle %0d got %b want %b", i, out_valid, exp_data.size() > 0);
      end
      if (exp_data.size() > 0) begin
        checks++;
        if (out_channel !== exp_ch[0] || out_data !== exp_data[0]) begin
          errors++; $display("FAIL rnd_beat: cycle %0d got ch%0d %0h want ch%0d %0h",
                             i, out_channel, out_data, exp_ch[0], exp_data[0]);
        end
      end
      checks++;
      if (overrun !== m_ovr || int'(overrun_count) != m_cnt) begin
        errors++; $display("FAIL rnd_ovr: cycle %0d got %b/%0d want %b/%0d",
                           i, overrun, overrun_count, m_ovr, m_cnt);
      end
    end
    frame_valid = 1'b0; clear_overrun = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_saturation();
    test_backpressure();
    test_double_buffer();
    test_overrun_sat();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
